// File: rtl/nibble_entry_pkg.sv
// Shared types and digit arithmetic for the two-digit operand entry stage.
// Define NIBBLE_ENTRY_BCD_EN to restrict digits to 0-9; the default build uses the full hex range.
package nibble_entry_pkg;

    typedef enum logic [1:0] {
        EDIT_HIGH = 2'd0,
        EDIT_LOW  = 2'd1,
        LOCKED    = 2'd2
    } entry_state_e;

    localparam int DIGIT_W = 4;

`ifdef NIBBLE_ENTRY_BCD_EN
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
`else
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd15;
`endif

    function automatic logic [DIGIT_W-1:0] digit_inc(input logic [DIGIT_W-1:0] d);
        return (d == DIGIT_MAX) ? '0 : d + DIGIT_W'(1);
    endfunction

    function automatic logic [DIGIT_W-1:0] digit_dec(input logic [DIGIT_W-1:0] d);
        return (d == '0) ? DIGIT_MAX : d - DIGIT_W'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton input path: 2-flop synchroniser, stability counter and a
// single-cycle pulse on each debounced press (releases produce nothing).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q;

    // The counter only runs while the synchronised level disagrees with the
    // debounced one, so any glitch shorter than the window restarts it.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            pulse_q <= deb_d & ~deb_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/nibble_entry_ctrl.sv
// Operand entry for the compare/display block: four debounced buttons edit a
// high and low digit, then lock them. Digit range follows NIBBLE_ENTRY_BCD_EN.
module nibble_entry_ctrl
    import nibble_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_sel,
    input  logic               btn_inc,
    input  logic               btn_dec,
    input  logic               btn_clr,
    output logic [DIGIT_W-1:0] dout_high,
    output logic [DIGIT_W-1:0] dout_low,
    output logic               dout_edit_high,
    output logic               dout_edit_low,
    output logic               dout_valid
);

    logic sel_p, inc_p, dec_p, clr_p;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (.clk(clk), .rst(rst), .btn_i(btn_sel), .pulse_o(sel_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (.clk(clk), .rst(rst), .btn_i(btn_inc), .pulse_o(inc_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (.clk(clk), .rst(rst), .btn_i(btn_dec), .pulse_o(dec_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (.clk(clk), .rst(rst), .btn_i(btn_clr), .pulse_o(clr_p));

    entry_state_e       state_q, state_d;
    logic [DIGIT_W-1:0] high_q, high_d;
    logic [DIGIT_W-1:0] low_q, low_d;
    logic               edit_high_q, edit_low_q, valid_q;

    // Only the highest-priority pulse acts in a cycle (clr > sel > inc > dec).
    always_comb begin
        state_d = state_q;
        high_d  = high_q;
        low_d   = low_q;
        if (clr_p) begin
            state_d = EDIT_HIGH;
            high_d  = '0;
            low_d   = '0;
        end else if (sel_p) begin
            case (state_q)
                EDIT_HIGH: state_d = EDIT_LOW;
                EDIT_LOW:  state_d = LOCKED;
                default:   state_d = EDIT_HIGH;
            endcase
        end else if (inc_p) begin
            if (state_q == EDIT_HIGH) high_d = digit_inc(high_q);
            else if (state_q == EDIT_LOW) low_d = digit_inc(low_q);
        end else if (dec_p) begin
            if (state_q == EDIT_HIGH) high_d = digit_dec(high_q);
            else if (state_q == EDIT_LOW) low_d = digit_dec(low_q);
        end
    end

    // Status flags are decoded from the next state so they are registered yet
    // stay aligned with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EDIT_HIGH;
            high_q      <= '0;
            low_q       <= '0;
            edit_high_q <= 1'b1;
            edit_low_q  <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            high_q      <= high_d;
            low_q       <= low_d;
            edit_high_q <= (state_d == EDIT_HIGH);
            edit_low_q  <= (state_d == EDIT_LOW);
            valid_q     <= (state_d == LOCKED);
        end
    end

    assign dout_high      = high_q;
    assign dout_low       = low_q;
    assign dout_edit_high = edit_high_q;
    assign dout_edit_low  = edit_low_q;
    assign dout_valid     = valid_q;

endmodule

// File: tb/tb_nibble_entry_ctrl.sv
// Directed, table-driven bench for nibble_entry_ctrl with DEBOUNCE_CYCLES=4;
// expected digit wrap values follow the package MAX for the chosen build.
module tb_nibble_entry_ctrl;
    import nibble_entry_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_sel = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_clr = 1'b0;
    logic [3:0] dout_high, dout_low;
    logic       dout_edit_high, dout_edit_low, dout_valid;

    int checks = 0;
    int failures = 0;

    nibble_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .btn_sel(btn_sel), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_clr(btn_clr),
        .dout_high(dout_high), .dout_low(dout_low),
        .dout_edit_high(dout_edit_high), .dout_edit_low(dout_edit_low), .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       sel, inc, dec, clr;
        logic [3:0] high, low;
        logic       eh, el, v;
    } vec_t;

    function automatic vec_t mkVec(input string n, input logic s, input logic i, input logic d,
                                   input logic c, input logic [3:0] h, input logic [3:0] l,
                                   input logic eh, input logic el, input logic v);
        vec_t r;
        r.name = n; r.sel = s; r.inc = i; r.dec = d; r.clr = c;
        r.high = h; r.low = l; r.eh = eh; r.el = el; r.v = v;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] h, input logic [3:0] l,
                               input logic eh, input logic el, input logic v);
        logic [10:0] act, exp;
        act = {dout_high, dout_low, dout_edit_high, dout_edit_low, dout_valid};
        exp = {h, l, eh, el, v};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got high=%h low=%h eh=%b el=%b v=%b, expected high=%h low=%h eh=%b el=%b v=%b",
                     name, dout_high, dout_low, dout_edit_high, dout_edit_low, dout_valid, h, l, eh, el, v);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Hold the given buttons long enough to act, then release long enough to re-arm.
    task automatic applyStimulus(input logic s, input logic i, input logic d, input logic c);
        btn_sel = s; btn_inc = i; btn_dec = d; btn_clr = c;
        repeat (8) @(posedge clk);
        #1 {btn_sel, btn_inc, btn_dec, btn_clr} = 4'b0000;
        repeat (8) @(posedge clk);
        #1;
    endtask

    vec_t vecs[10];
    int   wrapN;

    initial begin
        @(posedge clk); #1;
        doReset();
        checkOutput("reset", 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);

        // Glitch of 3 cycles must be ignored.
        btn_inc = 1'b1;
        repeat (3) @(posedge clk);
        #1 btn_inc = 1'b0;
        repeat (10) @(posedge clk);
        #1 checkOutput("glitch", 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);

        // Clean press: digit changes exactly 6 edges after the first sampling edge.
        btn_inc = 1'b1;
        repeat (6) @(posedge clk);
        #1 checkOutput("latency_n5", 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 checkOutput("latency_n6", 4'h1, 4'h0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 btn_inc = 1'b0;
        repeat (10) @(posedge clk);
        #1 checkOutput("no_repeat", 4'h1, 4'h0, 1'b1, 1'b0, 1'b0);

        // Entry and lock sequence.
        doReset();
        vecs[0] = mkVec("inc1",      0, 1, 0, 0, 4'h1, 4'h0,      1, 0, 0);
        vecs[1] = mkVec("inc2",      0, 1, 0, 0, 4'h2, 4'h0,      1, 0, 0);
        vecs[2] = mkVec("inc3",      0, 1, 0, 0, 4'h3, 4'h0,      1, 0, 0);
        vecs[3] = mkVec("sel_low",   1, 0, 0, 0, 4'h3, 4'h0,      0, 1, 0);
        vecs[4] = mkVec("dec_wrap",  0, 0, 1, 0, 4'h3, DIGIT_MAX, 0, 1, 0);
        vecs[5] = mkVec("sel_lock",  1, 0, 0, 0, 4'h3, DIGIT_MAX, 0, 0, 1);
        vecs[6] = mkVec("lock_inc",  0, 1, 0, 0, 4'h3, DIGIT_MAX, 0, 0, 1);
        vecs[7] = mkVec("lock_dec",  0, 0, 1, 0, 4'h3, DIGIT_MAX, 0, 0, 1);
        vecs[8] = mkVec("sel_high",  1, 0, 0, 0, 4'h3, DIGIT_MAX, 1, 0, 0);
        vecs[9] = mkVec("clr",       0, 0, 0, 1, 4'h0, 4'h0,      1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(vecs[k].sel, vecs[k].inc, vecs[k].dec, vecs[k].clr);
            checkOutput(vecs[k].name, vecs[k].high, vecs[k].low, vecs[k].eh, vecs[k].el, vecs[k].v);
        end

        // Wrap the high digit through its full range.
        wrapN = int'(DIGIT_MAX);
        for (int k = 0; k < wrapN; k++) applyStimulus(0, 1, 0, 0);
        checkOutput("at_max", DIGIT_MAX, 4'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("inc_wrap", 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("dec_wrap_high", DIGIT_MAX, 4'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("dec_plain", DIGIT_MAX - 4'd1, 4'h0, 1'b1, 1'b0, 1'b0);

        // clr beats inc in EDIT_LOW.
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) applyStimulus(0, 1, 0, 0);
        checkOutput("low_five", DIGIT_MAX - 4'd1, 4'h5, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("clr_inc", 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);

        // sel beats inc in EDIT_HIGH.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("high_two", 4'h2, 4'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("sel_inc", 4'h2, 4'h0, 1'b0, 1'b1, 1'b0);

        // Reset while a press is mid-debounce discards the partial count.
        btn_inc = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("mid_reset", 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1 checkOutput("post_rst_n5", 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 checkOutput("post_rst_n6", 4'h1, 4'h0, 1'b1, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 btn_inc = 1'b0;
        repeat (10) @(posedge clk);
        #1 checkOutput("post_rst_once", 4'h1, 4'h0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_entry_ctrl.md
# nibble_entry_ctrl

Upstream operand-entry stage for the two-digit compare/display block. Four pushbuttons are synchronised and debounced, and the user edits a high and a low 4-bit digit with them. Once both digits are entered, the block locks them. Its outputs `dout_high`/`dout_low` drive the comparator's `din_high`/`din_low` directly, and the edit flags can drive the display's decimal points or LEDs.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a debounced level changes. Board builds use 1_000_000.
- `clk` input 1: system clock. Single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `btn_sel` input 1: raw button, asynchronous. Advances the edit state.
- `btn_inc` input 1: raw button. Increments the selected digit.
- `btn_dec` input 1: raw button. Decrements the selected digit.
- `btn_clr` input 1: raw button. Clears both digits and returns to editing the high digit.
- `dout_high` output 4: high digit, feeds `din_high`.
- `dout_low` output 4: low digit, feeds `din_low`.
- `dout_edit_high` output 1: high digit is selected for edit.
- `dout_edit_low` output 1: low digit is selected for edit.
- `dout_valid` output 1: both digits locked. Downstream comparison is meaningful.

## Operation
- **Per-button input path:**
  - 2-flop synchroniser.
  - Debounce counter: resets whenever the synchronised level equals the debounced level. When it reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronised level and the counter clears.
  - Rising-edge detect on the debounced level produces a 1-cycle pulse.
  - Releases produce no pulse. Glitches shorter than `DEBOUNCE_CYCLES` are ignored.
- **FSM states:** EDIT_HIGH (reset state), EDIT_LOW, LOCKED.
  - sel pulse: EDIT_HIGH→EDIT_LOW→LOCKED→EDIT_HIGH.
  - clr pulse: any state→EDIT_HIGH, and both digits are set to 0.
- **Editing:**
  - inc/dec pulses modify only the digit selected by the current state.
  - In LOCKED, inc/dec pulses are ignored.
- **Digit arithmetic:** 4-bit modular with a configurable maximum MAX.
  - inc at MAX → 0.
  - dec at 0 → MAX.
  - Otherwise ±1.
- **Simultaneous pulses in one cycle:** priority clr > sel > inc > dec. Only the highest-priority pulse acts; the others are dropped, not queued.
- **Outputs (all registered):**
  - `dout_edit_high` = (state==EDIT_HIGH).
  - `dout_edit_low` = (state==EDIT_LOW).
  - `dout_valid` = (state==LOCKED).
- **Reset:**
  - `dout_high`=0, `dout_low`=0, `dout_edit_high`=1, `dout_edit_low`=0, `dout_valid`=0.
  - Synchronisers, debounced levels and counters are cleared to 0.
  - A button held through reset therefore produces one pulse after `DEBOUNCE_CYCLES` stable cycles.
  - Reset mid-debounce discards the partial count.

## Timing
- Raw rise at edge N (sampled by the first sync flop) gives a synchronised level at N+1.
- The debounced level rises at N+1+`DEBOUNCE_CYCLES` and the pulse is high during the following cycle.
- The digit/state register updates at N+2+`DEBOUNCE_CYCLES`.
- Total latency from press to output: `DEBOUNCE_CYCLES`+2 edges after the first sampling edge.
- One action per press. A held button does not auto-repeat.
- Back-to-back presses need release and press each stable for ≥`DEBOUNCE_CYCLES`.

## Configuration
- `NIBBLE_ENTRY_BCD_EN` defined: MAX=9.
  - Digits stay in 0–9, so the seven-segment decoder never shows A–F.
  - inc at 9 wraps to 0; dec at 0 wraps to 9.
- Not defined: MAX=15, full hex range, and inc at F wraps to 0.

## Structure
- Shared package `nibble_entry_pkg`:
  - FSM state enum (EDIT_HIGH, EDIT_LOW, LOCKED).
  - Digit width constant 4.
  - Digit MAX constant, selected by the macro.
- Sub-module `btn_debounce`: synchroniser + counter + edge pulse, parameterised by `DEBOUNCE_CYCLES`. Instantiated four times.
- Top module: FSM + two digit registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.

1. **Reset:** assert `rst` 2 cycles → `dout_high`=0, `dout_low`=0, `dout_edit_high`=1, `dout_valid`=0.
2. **Debounce:**
   - Glitch: `btn_inc` high 3 cycles then low → `dout_high` stays 0.
   - Clean press: high 10 cycles → `dout_high`=1 exactly 6 edges after the first sampling edge, and no second increment.
3. **Entry and lock:**
   - Sequence: inc×3, sel, dec×1, sel → `dout_high`=3, `dout_low`=9 (BCD) or F (hex), `dout_valid`=1.
   - Further inc/dec leave both digits unchanged.
4. **Wrap:** in EDIT_HIGH, press inc 10 times (BCD) / 16 times (hex) from 0 → `dout_high` returns to 0.
5. **Simultaneous events:**
   - `btn_clr` and `btn_inc` pressed together in EDIT_LOW with `dout_low`=5 → both digits 0, state EDIT_HIGH.
   - sel+inc together in EDIT_HIGH → state EDIT_LOW, `dout_high` unchanged.
6. **Reset mid-debounce:** press `btn_inc`, assert `rst` after 2 cycles while held → no increment before `DEBOUNCE_CYCLES` stable cycles after reset release, then exactly one increment to 1.
